fxp_dot_accum: RTL



---
 rtl/fxp_pkg.sv | 19 +
 rtl/fxp_dot_accum_if.sv | 31 +++
 rtl/fxp_result_fifo.sv | 73 +++++++
 rtl/fxp_dot_accum.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared Q16.16 definitions for the dot-product accumulator slice: formats,
// default latencies, Q16.16 constants and the result record.
package fxp_pkg;

  localparam int Q_FRAC       = 16;
  localparam int Q_W          = 32;
  localparam int MULT_LAT_DEF = 2;
  localparam int CNT_W_DEF    = 16;

  localparam logic [Q_W-1:0] ONE     = 32'h0001_0000;
  localparam logic [Q_W-1:0] SAT_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [Q_W-1:0]       data;
    logic [CNT_W_DEF-1:0] count;
    logic                 ovf;
  } res_rec_t;

endpackage

// File: rtl/fxp_dot_accum_if.sv
// Operand-tag and result handshake bundle for fxp_dot_accum.
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; valid never depends on ready, and the payload is held while
// valid is high and ready is low.
interface fxp_dot_accum_if
  import fxp_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             op_valid;
  logic             op_last;
  logic             op_ready;
  logic [Q_W-1:0]   prod;
  logic [Q_W-1:0]   acc_data;
  logic [CNT_W-1:0] acc_count;
  logic             acc_ovf;
  logic             acc_valid;
  logic             acc_ready;

  // Operand source plus result sink.
  modport master (
    output op_valid, op_last, prod, acc_ready,
    input  op_ready, acc_data, acc_count, acc_ovf, acc_valid
  );

  // The accumulator itself.
  modport slave (
    input  op_valid, op_last, prod, acc_ready,
    output op_ready, acc_data, acc_count, acc_ovf, acc_valid
  );
endinterface

// File: rtl/fxp_result_fifo.sv
// Small synchronous FIFO with asynchronous active-low reset; the head entry is
// presented combinationally from storage.
module fxp_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  assign do_pop  = pop && !empty;
  // A pop frees the head slot in the same edge, so a full FIFO can still take a push.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fxp_dot_accum.sv
// Dot-product accumulator behind a MULT_LAT-cycle Q16.16 multiplier.
// Optional build macro ACC_SAT_EN: saturate overflowed results to all-ones.
module fxp_dot_accum
  import fxp_pkg::*;
#(
  parameter int MULT_LAT  = MULT_LAT_DEF,
  parameter int ACC_W     = 40,
  parameter int RES_DEPTH = 2,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic           clk,
  input logic           reset,
  fxp_dot_accum_if.slave bus
);
  localparam int CW = $clog2(RES_DEPTH + 1);
  localparam int LW = $clog2(MULT_LAT + 1);
  localparam int OW = CW + LW + 1;

  typedef struct packed {
    logic [Q_W-1:0]   data;
    logic [CNT_W-1:0] count;
    logic             ovf;
  } rec_t;

  localparam int REC_W = $bits(rec_t);

  logic [MULT_LAT-1:0] tag_valid_q, tag_valid_d;
  logic [MULT_LAT-1:0] tag_last_q, tag_last_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                first_q, first_d;

  logic             issue;
  logic             op_ready;
  logic             d_valid, d_last;
  logic [ACC_W-1:0] prod_ext, sum;
  logic [LW-1:0]    lasts_in_flight;
  logic [OW-1:0]    occupancy;
  logic [Q_W-1:0]   result32;
  rec_t             push_rec, head_rec;
  logic [REC_W-1:0] head_bits;
  logic [CW-1:0]    buf_count;
  logic             buf_empty, buf_full;
  logic             push, pop;

  // Credit every vector end already issued, so the buffer can never be pushed when full.
  always_comb begin
    lasts_in_flight = '0;
    for (int i = 0; i < MULT_LAT; i++) begin
      lasts_in_flight = lasts_in_flight + LW'(tag_last_q[i]);
    end
    occupancy = OW'(buf_count) + OW'(lasts_in_flight);
    op_ready  = (occupancy < OW'(RES_DEPTH));
  end

  assign issue    = bus.op_valid && op_ready;
  assign d_valid  = tag_valid_q[MULT_LAT-1];
  assign d_last   = tag_last_q[MULT_LAT-1];
  assign prod_ext = ACC_W'(bus.prod);
  assign sum      = acc_q + prod_ext;

  always_comb begin
    tag_valid_d[0] = issue;
    tag_last_d[0]  = issue && bus.op_last;
    for (int i = 1; i < MULT_LAT; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_last_d[i]  = tag_last_q[i-1];
    end
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    first_d = first_q;
    if (d_valid) begin
      if (first_q) begin
        acc_d = prod_ext;
        cnt_d = CNT_W'(1);
        ovf_d = 1'b0;
      end else begin
        acc_d = sum;
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        ovf_d = ovf_q || (sum[ACC_W-1:Q_W] != '0);
      end
      first_d = d_last;
    end
  end

`ifdef ACC_SAT_EN
  assign result32 = ovf_d ? SAT_MAX : acc_d[Q_W-1:0];
`else
  assign result32 = acc_d[Q_W-1:0];
`endif

  // The record carries the values being written this edge, including the last product.
  always_comb begin
    push_rec.data  = result32;
    push_rec.count = cnt_d;
    push_rec.ovf   = ovf_d;
  end

  assign push = d_valid && d_last;
  assign pop  = bus.acc_valid && bus.acc_ready;

  fxp_result_fifo #(
    .W     (REC_W),
    .DEPTH (RES_DEPTH),
    .CW    (CW)
  ) u_res_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .head      (head_bits),
    .count     (buf_count),
    .empty     (buf_empty),
    .full      (buf_full)
  );

  assign head_rec      = head_bits;
  assign bus.op_ready  = op_ready;
  assign bus.acc_valid = !buf_empty;
  assign bus.acc_data  = head_rec.data;
  assign bus.acc_count = head_rec.count;
  assign bus.acc_ovf   = head_rec.ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid_q <= '0;
      tag_last_q  <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      tag_valid_q <= tag_valid_d;
      tag_last_q  <= tag_last_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      first_q     <= first_d;
    end
  end

  logic unused_full;
  assign unused_full = buf_full;

endmodule
